// File: rtl/rx_intf_pkg.sv
// Shared definitions for the RX DMA transfer scheduler: state encoding and
// the default symbol-length width.
package rx_intf_pkg;

    localparam int MAX_BIT_NUM_DMA_SYMBOL_DEF = 14;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_LAST = 3'd3,
        ST_GAP       = 3'd4,
        ST_HALT      = 3'd5
    } sched_state_t;

endpackage

// File: rtl/rx_intf_desc_fifo.sv
// Synchronous descriptor queue with registered occupancy and full/empty flags.
// A push into a full queue is accepted only when a pop happens in the same cycle.
module rx_intf_desc_fifo
    import rx_intf_pkg::*;
#(
    parameter int DATA_W     = MAX_BIT_NUM_DMA_SYMBOL_DEF,
    parameter int DEPTH_BITS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic              drop
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0]   CNT_ZERO = (DEPTH_BITS+1)'(0);
    localparam logic [DEPTH_BITS:0]   CNT_ONE  = (DEPTH_BITS+1)'(1);
    localparam logic [DEPTH_BITS:0]   CNT_FULL = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS-1:0] PTR_ZERO = DEPTH_BITS'(0);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);

    logic [DATA_W-1:0]     mem_r [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_r;
    logic [DEPTH_BITS-1:0] rd_ptr_r;
    logic [DEPTH_BITS:0]   count_r;
    logic                  full_r;
    logic                  empty_r;
    logic                  wr_en_s;
    logic                  rd_en_s;
    logic                  drop_s;
    logic [DEPTH_BITS:0]   count_nxt_s;

    // Accept/drop decision and next occupancy
    always_comb begin
        rd_en_s     = pop && !empty_r;
        wr_en_s     = push && (!full_r || rd_en_s);
        drop_s      = push && full_r && !rd_en_s;
        count_nxt_s = count_r;
        case ({wr_en_s, rd_en_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_FULL);
            empty_r <= (count_nxt_s == CNT_ZERO);
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;
    assign drop  = drop_s;

endmodule

// File: rtl/rx_intf_dma_sched.sv
// Schedules one stream-master transfer per queued descriptor: waits for enough
// FIFO data, pulses start, watches for tlast with a timeout, then enforces a gap.
module rx_intf_dma_sched
    import rx_intf_pkg::*;
#(
    parameter int MAX_BIT_NUM_DMA_SYMBOL = MAX_BIT_NUM_DMA_SYMBOL_DEF,
    parameter int DESC_DEPTH_BITS        = 3,
    parameter int TIMEOUT_BITS           = 16,
    parameter int GAP_BITS               = 5
) (
    input  logic                              M_AXIS_ACLK,
    input  logic                              M_AXIS_ARESETN,
    input  logic                              enable,
    input  logic                              desc_valid,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] desc_len,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] data_count,
    input  logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    input  logic                              m_axis_tlast,
    input  logic [TIMEOUT_BITS-1:0]           timeout_cfg,
    input  logic [GAP_BITS-1:0]               gap_cfg,
    output logic                              start_1trans,
    output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] num_dma_symbol,
    output logic                              desc_full,
    output logic                              desc_overflow,
    output logic                              busy,
    output logic                              timeout_err
);

    localparam int W = MAX_BIT_NUM_DMA_SYMBOL;
    localparam logic [TIMEOUT_BITS-1:0] TO_ZERO  = TIMEOUT_BITS'(0);
    localparam logic [TIMEOUT_BITS-1:0] TO_ONE   = TIMEOUT_BITS'(1);
    localparam logic [TIMEOUT_BITS-1:0] TO_MAX   = {TIMEOUT_BITS{1'b1}};
    localparam logic [GAP_BITS-1:0]     GAP_ZERO = GAP_BITS'(0);
    localparam logic [GAP_BITS-1:0]     GAP_ONE  = GAP_BITS'(1);
    localparam logic [W-1:0]            LEN_ZERO = W'(0);

    sched_state_t          state_r;
    logic [W-1:0]          num_r;
    logic                  start_r;
    logic                  busy_r;
    logic                  overflow_r;
    logic                  timeout_err_r;
    logic [TIMEOUT_BITS-1:0] to_cnt_r;
    logic [GAP_BITS-1:0]   gap_cnt_r;

    logic                  pop_s;
    logic                  data_ready_s;
    logic                  last_hs_s;
    logic                  timeout_hit_s;
    logic [W-1:0]          fifo_head_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  fifo_drop_s;

    rx_intf_desc_fifo #(
        .DATA_W     (W),
        .DEPTH_BITS (DESC_DEPTH_BITS)
    ) u_desc_fifo (
        .clk       (M_AXIS_ACLK),
        .rst_n     (M_AXIS_ARESETN),
        .push      (desc_valid),
        .push_data (desc_len),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .drop      (fifo_drop_s)
    );

    // Transition conditions; data check is widened so length+1 never wraps
    always_comb begin
        if ((state_r == ST_IDLE) && enable && !fifo_empty_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        data_ready_s  = ({1'b0, data_count} > {1'b0, num_r});
        last_hs_s     = m_axis_tvalid && m_axis_tready && m_axis_tlast;
        timeout_hit_s = (timeout_cfg != TO_ZERO) && (to_cnt_r == timeout_cfg);
    end

    // Scheduler FSM with registered outputs
    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            state_r       <= ST_IDLE;
            num_r         <= LEN_ZERO;
            start_r       <= 1'b0;
            busy_r        <= 1'b0;
            overflow_r    <= 1'b0;
            timeout_err_r <= 1'b0;
            to_cnt_r      <= TO_ZERO;
            gap_cnt_r     <= GAP_ZERO;
        end else begin
            if (fifo_drop_s) begin
                overflow_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        state_r <= ST_WAIT_DATA;
                        num_r   <= fifo_head_s;
                        busy_r  <= 1'b1;
                    end
                end
                ST_WAIT_DATA: begin
                    if (data_ready_s) begin
                        state_r <= ST_START;
                        start_r <= 1'b1;
                    end
                end
                ST_START: begin
                    state_r  <= ST_WAIT_LAST;
                    start_r  <= 1'b0;
                    to_cnt_r <= TO_ONE;
                end
                ST_WAIT_LAST: begin
                    // A tlast handshake wins over a timeout landing on the same cycle
                    if (last_hs_s) begin
                        state_r   <= ST_GAP;
                        gap_cnt_r <= GAP_ONE;
                    end else if (timeout_hit_s) begin
                        state_r       <= ST_HALT;
                        timeout_err_r <= 1'b1;
                    end else if (to_cnt_r != TO_MAX) begin
                        to_cnt_r <= to_cnt_r + TO_ONE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r >= gap_cfg) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_ONE;
                    end
                end
                ST_HALT: begin
                    if (!enable) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    start_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign start_1trans   = start_r;
    assign num_dma_symbol = num_r;
    assign desc_full      = fifo_full_s;
    assign desc_overflow  = overflow_r;
    assign busy           = busy_r;
    assign timeout_err    = timeout_err_r;

endmodule

// File: doc/rx_intf_dma_sched.md
RX_INTF_DMA_SCHED -- requirements
Module: rx_intf_dma_sched

Interface
REQ-001 SHALL have parameter MAX_BIT_NUM_DMA_SYMBOL, default 14: width of lengths and FIFO data count.
REQ-002 SHALL have parameter DESC_DEPTH_BITS, default 3: log2 of descriptor queue depth (8 entries).
REQ-003 SHALL have parameter TIMEOUT_BITS, default 16: width of the transfer timeout counter.
REQ-004 SHALL have parameter GAP_BITS, default 5: width of the inter-packet gap counter.
REQ-005 SHALL have M_AXIS_ACLK  in  1  sole clock; one clock, all logic on its rising edge.
REQ-006 SHALL have M_AXIS_ARESETN  in  1  reset, synchronous, active-low.
REQ-007 SHALL have enable  in  1  allows new transfers to start.
REQ-008 SHALL have desc_valid  in  1  one-cycle push of a packet descriptor.
REQ-009 SHALL have desc_len  in  MAX_BIT_NUM_DMA_SYMBOL  packet beats minus one.
REQ-010 SHALL have data_count  in  MAX_BIT_NUM_DMA_SYMBOL  beats currently held in the stream FIFO.
REQ-011 SHALL have m_axis_tvalid, m_axis_tready, m_axis_tlast  in  1 each  monitored stream handshake.
REQ-012 SHALL have timeout_cfg  in  TIMEOUT_BITS  WAIT_LAST cycle limit; 0 disables the timeout.
REQ-013 SHALL have gap_cfg  in  GAP_BITS  idle cycles after each packet.
REQ-014 SHALL have start_1trans  out  1  one-cycle start pulse to the stream master.
REQ-015 SHALL have num_dma_symbol  out  MAX_BIT_NUM_DMA_SYMBOL  length for the active transfer.
REQ-016 SHALL have desc_full  out  1  descriptor queue full.
REQ-017 SHALL have desc_overflow  out  1  sticky: a push arrived while the queue was full.
REQ-018 SHALL have busy  out  1  state is not IDLE.
REQ-019 SHALL have timeout_err  out  1  sticky timeout flag.

Function
REQ-020 SHALL implement states IDLE, WAIT_DATA, START, WAIT_LAST, GAP, HALT.
REQ-021 IDLE SHALL go to WAIT_DATA when enable=1 and the queue is non-empty, popping the head into num_dma_symbol on that edge.
REQ-022 WAIT_DATA SHALL go to START when data_count > num_dma_symbol, compared unsigned at width MAX_BIT_NUM_DMA_SYMBOL+1 so that length+1 cannot wrap.
REQ-023 START SHALL drive start_1trans=1 for exactly that one cycle (registered output) and then go to WAIT_LAST.
REQ-024 WAIT_LAST SHALL go to GAP on the first cycle where m_axis_tvalid, m_axis_tready and m_axis_tlast are all 1.
REQ-025 WAIT_LAST SHALL count cycles from 1; if timeout_cfg≠0 and the count reaches timeout_cfg with no tlast handshake, it SHALL set timeout_err and go to HALT.
REQ-026 If the tlast handshake and the timeout occur in the same cycle, the handshake SHALL take priority: go to GAP, timeout_err unchanged.
REQ-027 GAP SHALL stay for gap_cfg cycles (0 = one cycle minimum) and then return to IDLE, so start_1trans always has a low phase between pulses.
REQ-028 HALT SHALL hold until enable=0, then go to IDLE; timeout_err SHALL clear only on reset.
REQ-029 Deasserting enable SHALL NOT abort a transfer already in progress; it only blocks the IDLE exit.
REQ-030 num_dma_symbol SHALL stay stable from the pop until the next pop.
REQ-031 Descriptor queue: FIFO, DESC_DEPTH entries.
  - A push when full SHALL be dropped and SHALL set desc_overflow.
  - A push and a pop in the same cycle SHALL both take effect, including when full (no overflow).
  - Pointers SHALL wrap modulo DESC_DEPTH.
REQ-032 A descriptor pushed in cycle t SHALL be poppable no earlier than cycle t+1.

Reset
REQ-033 On reset: state=IDLE; queue empty; counters 0; outputs start_1trans, num_dma_symbol, desc_overflow, timeout_err, busy all 0; desc_full 0.
REQ-034 Reset asserted mid-transfer SHALL abandon the transfer and discard all queued descriptors; the first pulse after release requires a fresh push.

Structure
REQ-035 Package rx_intf_pkg SHALL hold the state encodings and the MAX_BIT_NUM_DMA_SYMBOL default.
REQ-036 The descriptor queue SHALL be sub-module rx_intf_desc_fifo (sync, registered count, full/empty flags).

Verification
REQ-037 Push len=7, data_count=8 after 20 cycles -> start_1trans is one cycle high, 1 cycle after WAIT_DATA exit, num_dma_symbol=7; tlast handshake -> busy=0 after gap_cfg+1 cycles.
REQ-038 data_count=7 with len=7 -> no pulse; data_count=8 -> pulse.
REQ-039 Push 9 descriptors back-to-back with enable=0 -> desc_full after 8, desc_overflow=1, 8 pulses when enabled with lengths in order.
REQ-040 timeout_cfg=100 with no tlast -> timeout_err=1 at WAIT_LAST cycle 100, no further pulses until enable toggles 1→0→1.
REQ-041 tlast handshake exactly at cycle 100 -> timeout_err=0, normal completion.
REQ-042 Reset during WAIT_LAST with 3 queued -> all outputs 0, no pulse after release.
